core_dmem_arbiter: RTL
======================

// Module: core_dmem_arbiter
// PURPOSE
//  Shares one single-port synchronous data memory among CORE_COUNT processor cores of the multi-core processor.
//  Each core raises a request with address/data/write-enable; the arbiter grants one core at a time (round-robin),
//  drives the shared memory port, and returns an ack pulse (plus read data for loads). Sits between the cores'
//  data-memory ports and the data RAM.
// PARAMETERS
//  REG_WIDTH   12  data word width (bits)
//  ADDR_WIDTH  8   data memory address width (bits)
//  CORE_COUNT  4   number of requesting cores (>=2)
// PORTS
//  clk         in   1                      system clock, all state on rising edge
//  rst         in   1                      asynchronous, active-high reset
//  coreReq     in   CORE_COUNT             per-core access request, level
//  coreWrEn    in   CORE_COUNT             per-core 1=write, 0=read (valid while coreReq)
//  coreAddr    in   ADDR_WIDTH*CORE_COUNT  per-core address, core i at [ADDR_WIDTH*i+:ADDR_WIDTH]
//  coreWrData  in   REG_WIDTH*CORE_COUNT   per-core write data, core i at [REG_WIDTH*i+:REG_WIDTH]
//  coreAck     out  CORE_COUNT             one-hot, 1-cycle pulse: access of core i completed
//  coreRdData  out  REG_WIDTH              read data, broadcast; valid only in the coreAck cycle of a read
//  memEn       out  1                      shared memory access strobe
//  memWrEn     out  1                      shared memory write enable
//  memAddr     out  ADDR_WIDTH             shared memory address
//  memWrData   out  REG_WIDTH              shared memory write data
//  memRdData   in   REG_WIDTH              shared memory read data, 1-cycle latency after memEn
//  busy        out  1                      high in ISSUE and RESP
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE; coreAck=0, memEn=0, memWrEn=0, memAddr=0, memWrData=0, busy=0,
//    round-robin pointer=0, latched grant=0. In-flight access is aborted; no ack is issued for it.
//  - FSM: IDLE -> ISSUE (if |coreReq) -> RESP -> IDLE (unconditional). 3 cycles per access, no back-to-back issue.
//  - IDLE: select winner = first core with coreReq set, searching from pointer upward, wrapping CORE_COUNT-1 -> 0.
//    On the edge: latch winner index, coreAddr/coreWrData/coreWrEn of winner; pointer <= (winner+1) mod CORE_COUNT.
//  - ISSUE: memEn=1, memAddr/memWrData/memWrEn from latched registers (registered outputs, stable whole cycle).
//  - RESP: coreAck[winner]=1 (exactly one bit); coreRdData = memRdData (combinational pass-through);
//    memEn=0, memWrEn=0. Write acks: coreRdData don't-care.
//  - coreRdData = 0 outside RESP.
//  - Requester rule: hold coreReq and payload stable until ack; deassert or present next request on the edge
//    that samples ack. Payload changes after the IDLE latch edge are ignored for that access.
//  - coreReq dropped before grant: request silently withdrawn. Dropped after latch: access still completes, ack issued.
//  - No request in IDLE: remain IDLE, outputs idle, pointer unchanged.
//  - Simultaneous requests from all cores: served in pointer order, each core once per CORE_COUNT grants (no starvation).
//  - Non-power-of-2 CORE_COUNT: pointer wraps at CORE_COUNT-1 explicitly, never indexes an absent core.
// CONFIGURATION
//  - FIXED_PRIORITY_EN defined: winner = lowest-index requesting core; pointer register removed/held 0.
//    Core 0 may starve others under continuous load (intended for debug/real-time core 0).
//  - FIXED_PRIORITY_EN undefined (default): round-robin as above.
// TESTING
//  1. Reset mid-ISSUE with core 2 writing addr 0x10 -> memEn/memWrEn drop immediately, no coreAck; RAM[0x10] unchanged.
//  2. Core 1 write addr 0x05 data 0xABC, then read 0x05 -> ack 3 cycles after each req; read ack has coreRdData=0xABC.
//  3. All 4 cores req reads from reset -> acks in order 0,1,2,3, each 3 cycles apart; exactly one ack bit at a time.
//  4. Core 3 continuous req + core 0 req after first grant -> grant order 3,0,3,0 (round-robin wrap 3->0).
//  5. Core 2 drops req in same IDLE cycle it would have lost -> never acked; core 2 req drop after latch -> acked once.
//  6. FIXED_PRIORITY_EN: cores 0 and 1 continuous -> only core 0 acked; release core 0 -> core 1 acked next access.

Source files
------------

// File: rtl/core_dmem_arbiter.sv
// core_dmem_arbiter: shares one single-port synchronous data RAM among CORE_COUNT cores.
// One access takes three cycles: IDLE (arbitrate and latch), ISSUE (drive RAM), RESP (ack and read data).
// Build macro FIXED_PRIORITY_EN: the lowest-index requester always wins and the rotating pointer is removed.
module core_dmem_arbiter #(
  parameter int REG_WIDTH  = 12,
  parameter int ADDR_WIDTH = 8,
  parameter int CORE_COUNT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CORE_COUNT-1:0]            coreReq,
  input  logic [CORE_COUNT-1:0]            coreWrEn,
  input  logic [ADDR_WIDTH*CORE_COUNT-1:0] coreAddr,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]  coreWrData,
  output logic [CORE_COUNT-1:0]            coreAck,
  output logic [REG_WIDTH-1:0]             coreRdData,
  output logic                             memEn,
  output logic                             memWrEn,
  output logic [ADDR_WIDTH-1:0]            memAddr,
  output logic [REG_WIDTH-1:0]             memWrData,
  input  logic [REG_WIDTH-1:0]             memRdData,
  output logic                             busy
);

  localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        grant;
  logic [IDX_W-1:0]        winner;
  logic                    found;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [REG_WIDTH-1:0]    sel_data;
  logic                    sel_we;
`ifndef FIXED_PRIORITY_EN
  logic [IDX_W-1:0]        ptr;
`endif

  // Pick the first requesting core, starting at the pointer (or at core 0 in fixed priority)
  always_comb begin
`ifndef FIXED_PRIORITY_EN
    logic [IDX_W:0] idx;
    idx = '0;
`endif
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
`ifdef FIXED_PRIORITY_EN
      if (!found && coreReq[k]) begin
        found  = 1'b1;
        winner = IDX_W'(k);
      end
`else
      // Explicit wrap keeps the search inside 0..CORE_COUNT-1 for any core count
      idx = {1'b0, ptr} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(CORE_COUNT)) idx = idx - (IDX_W+1)'(CORE_COUNT);
      if (!found && coreReq[idx[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
`endif
    end
  end

  // Route the winner's payload toward the latch registers
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_we   = 1'b0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (winner == IDX_W'(k)) begin
        sel_addr = coreAddr[ADDR_WIDTH*k +: ADDR_WIDTH];
        sel_data = coreWrData[REG_WIDTH*k +: REG_WIDTH];
        sel_we   = coreWrEn[k];
      end
    end
  end

  // Next-state: one access walks IDLE -> ISSUE -> RESP -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latch the grant and drive the memory port as registered outputs during ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      memEn     <= 1'b0;
      memWrEn   <= 1'b0;
      memAddr   <= '0;
      memWrData <= '0;
`ifndef FIXED_PRIORITY_EN
      ptr       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant     <= winner;
            memEn     <= 1'b1;
            memWrEn   <= sel_we;
            memAddr   <= sel_addr;
            memWrData <= sel_data;
`ifndef FIXED_PRIORITY_EN
            ptr       <= (winner == IDX_W'(CORE_COUNT-1)) ? '0 : winner + 1'b1;
`endif
          end
        end
        ISSUE: begin
          memEn   <= 1'b0;
          memWrEn <= 1'b0;
        end
        default: begin
          memEn   <= 1'b0;
          memWrEn <= 1'b0;
        end
      endcase
    end
  end

  // Response side: one-hot ack and read-data pass-through only in RESP
  always_comb begin
    coreAck    = '0;
    coreRdData = '0;
    busy       = (state != IDLE);
    if (state == RESP) begin
      coreRdData = memRdData;
      for (int k = 0; k < CORE_COUNT; k++) begin
        coreAck[k] = (grant == IDX_W'(k));
      end
    end
  end

endmodule
